four_ch_delay_top: RTL and testbench
====================================

Name: four_ch_delay_top

Overview:
- SPI-slave front end plus 4-channel delay-and-sum core.
- Receives framed 14-bit ADC samples over SPI: a header word, then channels 0..3.
- Delays each channel by a per-channel frame count, sums the four delayed samples and outputs the average as signed dn.
- Marks each new result with head_flag and returns the latest dn on miso.

Parameters:
- D0, 0: frame delay applied to channel 0.
- D1, 1: frame delay applied to channel 1.
- D2, 2: frame delay applied to channel 2.
- D3, 3: frame delay applied to channel 3.
- MAX_DELAY, 7: depth of each delay line; every Dn must be <= MAX_DELAY.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rstn  in  1  synchronous, active-high reset (asserted when 1, despite the name).
- sck  in  1  SPI clock, asynchronous to clk, idle low.
- mosi  in  1  SPI data in; MSB first, sampled on sck rising edge.
- cs  in  1  chip select, active low; one 14-bit word per cs-low window.
- miso  out  1  SPI data out: latest dn, MSB first.
- dn  out  14 signed  delay-and-sum result.
- head_flag  out  1  one-clk pulse marking a new dn.

Behaviour:
- Synchronise sck, mosi and cs with 2-flop synchronisers on clk; detect edges on the synchronised signals.
- Minimum SPI half-period is 4 clk.
- Word receive:
  - cs falling clears the bit counter.
  - Each sck rising edge while cs is low shifts mosi into a 14-bit register, MSB first.
  - cs rising completes the word only if exactly 14 bits were received; otherwise the word is discarded.
- Frame FSM, states WAIT_HDR, CH0, CH1, CH2, CH3:
  - WAIT_HDR: word == 14'h0FFF -> CH0; any other word is discarded and the FSM stays in WAIT_HDR.
  - CHn: the word is stored as signed sample n, then go to the next state. 0x0FFF in a CH state is data.
  - After CH3 completes: push all 4 samples into their delay lines, compute the result, return to WAIT_HDR.
- Delay lines:
  - One shift register per channel, MAX_DELAY+1 entries, advanced once per completed frame.
  - Channel n uses the sample from Dn frames earlier; delay 0 means the current frame.
  - Unfilled entries read 0.
- Arithmetic:
  - sum is 16-bit signed (sign-extended sum of the four delayed samples).
  - dn = sum >>> 2, arithmetic, floor rounding; no overflow is possible.
- Timing:
  - dn registers on the clk after the CH3 word completes.
  - head_flag is high for exactly the next clk, so dn is stable before head_flag rises and stays stable until the next frame.
- miso:
  - On cs falling, load a shift register with the current dn.
  - Drive its MSB on miso; shift left on each sck falling edge while cs is low.
  - When cs is high, miso = 0.
- Reset:
  - dn=0, head_flag=0, miso=0, delay lines cleared, FSM to WAIT_HDR, bit counter cleared.
  - Reset mid-frame aborts the frame; no partial result is produced.
- Simultaneous events: cs rising and a completed word in the same clk is handled as word-complete first, then idle.

Decomposition:
- Shared package four_ch_delay_pkg: WORD_W=14, NUM_CH=4, HEADER=14'h0FFF, SUM_W=16, FSM state enum.
- One sub-module spi_word_rx: synchronisers, edge detect, 14-bit shift-in, word_valid/word outputs, miso shift-out.
- The FSM, delay lines and adder stay in the top.

Test Plan:
- Reset pulse, no SPI traffic -> dn=0, head_flag=0, miso=0.
- Four frames, each header 0x0FFF then samples 100,200,300,400, default delays -> dn = 25, 75, 150, 250, one head_flag pulse per frame.
- Steady frames of -8000 on all channels until delays fill -> dn = -8000; all channels -8192 -> dn = -8192 (no overflow).
- Steady samples -1,0,0,0 -> dn = -1 (floor rounding); samples 1,0,0,0 -> dn = 0.
- Word 0x1234 sent before the header -> ignored; the following full frame processes normally. A 13-bit cs window is discarded. 0x0FFF as CH2 data is taken as 4095.
- Read miso during a cs-low window after dn=250 -> bits 00000011111010 MSB first. Assert reset mid-frame -> no head_flag; the next full frame is accepted.

Source files
------------

// File: rtl/four_ch_delay_pkg.sv
// Shared definitions for the four-channel SPI delay-and-sum block.
// Holds word/sum widths, the frame header value and the frame FSM states.
package four_ch_delay_pkg;

  localparam int unsigned WORD_W = 14;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [WORD_W-1:0] HEADER = 14'h0FFF;

  typedef logic signed [WORD_W-1:0] sample_t;

  typedef enum logic [2:0] {
    WAIT_HDR,
    CH0,
    CH1,
    CH2,
    CH3
  } frame_state_e;

endpackage

// File: rtl/spi_word_rx.sv
// SPI slave word engine: synchronises sck/mosi/cs into clk, shifts in
// 14-bit MSB-first words and shifts tx_word out on miso.
// Ports:
//   clk, rstn   - system clock, synchronous active-high reset
//   sck,mosi,cs - raw SPI pins (cs active low)
//   tx_word     - value loaded into the miso shifter on cs falling
//   word_valid  - one-clk pulse when a complete 14-bit word is received
//   word        - received word, valid with word_valid
//   miso        - SPI data out, 0 while cs is high
module spi_word_rx
  import four_ch_delay_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  input  logic [WORD_W-1:0] tx_word,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic              miso
);

  // [0],[1] form the synchroniser, [2] is the previous synchronised value
  logic [2:0]        sck_q, sck_d;
  logic [2:0]        cs_q, cs_d;
  logic [1:0]        mosi_q, mosi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              miso_q, miso_d;

  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_low;

  // Edge detection, shift-in/out and word completion
  always_comb begin
    sck_d        = {sck_q[1:0], sck};
    cs_d         = {cs_q[1:0], cs};
    mosi_d       = {mosi_q[0], mosi};
    cnt_d        = cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;

    sck_rise = sck_q[1] & ~sck_q[2];
    sck_fall = ~sck_q[1] & sck_q[2];
    cs_fall  = ~cs_q[1] & cs_q[2];
    cs_rise  = cs_q[1] & ~cs_q[2];
    cs_low   = ~cs_q[1];

    if (cs_fall) begin
      cnt_d = '0;
      tx_d  = tx_word;
    end else if (cs_low) begin
      if (sck_rise) begin
        rx_d = {rx_q[WORD_W-2:0], mosi_q[1]};
        // saturate so an over-long window can never wrap back to 14
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      if (sck_fall) tx_d = {tx_q[WORD_W-2:0], 1'b0};
    end

    if (cs_rise && (cnt_q == CNT_W'(WORD_W))) begin
      word_valid_d = 1'b1;
      word_d       = rx_q;
    end

    miso_d = cs_low & tx_d[WORD_W-1];
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      sck_q        <= '0;
      cs_q         <= '1;
      mosi_q       <= '0;
      cnt_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      sck_q        <= sck_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      cnt_q        <= cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      miso_q       <= miso_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;
  assign miso       = miso_q;

endmodule

// File: rtl/four_ch_delay_top.sv
// Four-channel delay-and-sum core behind an SPI slave front end.
// Frames are a 0x0FFF header followed by channel 0..3 samples; each channel
// is delayed by Dn frames, the four taps are summed and averaged into dn.
// Ports:
//   clk, rstn      - system clock, synchronous active-high reset
//   sck, mosi, cs  - SPI slave inputs
//   miso           - latest dn, MSB first during a cs-low window
//   dn             - signed average of the four delayed samples
//   head_flag      - one-clk pulse, one clk after dn updates
module four_ch_delay_top
  import four_ch_delay_pkg::*;
#(
  parameter int unsigned D0        = 0,
  parameter int unsigned D1        = 1,
  parameter int unsigned D2        = 2,
  parameter int unsigned D3        = 3,
  parameter int unsigned MAX_DELAY = 7
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sck,
  input  logic                     mosi,
  input  logic                     cs,
  output logic                     miso,
  output logic signed [WORD_W-1:0] dn,
  output logic                     head_flag
);

  logic              word_valid;
  logic [WORD_W-1:0] word;

  frame_state_e state_q, state_d;
  logic [NUM_CH-2:0] cap_en_c;
  logic              frame_done_c;

  // Channels 0..2 are held here; channel 3 is used straight from the word
  sample_t samp_q [NUM_CH-1];
  sample_t samp_d [NUM_CH-1];
  // History of past frames; the current frame is entry "-1", giving
  // MAX_DELAY+1 selectable taps in total
  sample_t dl_q [NUM_CH][MAX_DELAY];
  sample_t dl_d [NUM_CH][MAX_DELAY];
  sample_t cur  [NUM_CH];
  sample_t tap  [NUM_CH];

  logic signed [SUM_W-1:0] sum_c;
  sample_t dn_q, dn_d;
  logic    done_q, done_d;
  logic    head_flag_q, head_flag_d;

  spi_word_rx u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .sck        (sck),
    .mosi       (mosi),
    .cs         (cs),
    .tx_word    (dn_q),
    .word_valid (word_valid),
    .word       (word),
    .miso       (miso)
  );

  // Frame FSM: state register
  always_ff @(posedge clk) begin
    if (rstn) state_q <= WAIT_HDR;
    else      state_q <= state_d;
  end

  // Frame FSM: next state
  always_comb begin
    state_d = state_q;
    if (word_valid) begin
      case (state_q)
        WAIT_HDR: if (word == HEADER) state_d = CH0;
        CH0:      state_d = CH1;
        CH1:      state_d = CH2;
        CH2:      state_d = CH3;
        CH3:      state_d = WAIT_HDR;
        default:  state_d = WAIT_HDR;
      endcase
    end
  end

  // Frame FSM: outputs
  always_comb begin
    cap_en_c     = '0;
    frame_done_c = 1'b0;
    if (word_valid) begin
      case (state_q)
        CH0:     cap_en_c[0]  = 1'b1;
        CH1:     cap_en_c[1]  = 1'b1;
        CH2:     cap_en_c[2]  = 1'b1;
        CH3:     frame_done_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Current-frame samples
  always_comb begin
    for (int i = 0; i < NUM_CH - 1; i++) cur[i] = samp_q[i];
    cur[NUM_CH-1] = $signed(word);
  end

  // Per-channel tap: delay 0 bypasses the history
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tap
    localparam int unsigned DLY = (g == 0) ? D0 : (g == 1) ? D1 : (g == 2) ? D2 : D3;
    if (DLY == 0) begin : g_now
      assign tap[g] = cur[g];
    end else begin : g_hist
      assign tap[g] = dl_q[g][DLY-1];
    end
  end

  // Sign-extended sum of the four taps
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_CH; i++) sum_c = sum_c + SUM_W'(tap[i]);
  end

  // Sample capture, history shift and result
  always_comb begin
    for (int i = 0; i < NUM_CH - 1; i++)
      samp_d[i] = cap_en_c[i] ? $signed(word) : samp_q[i];
    dl_d        = dl_q;
    dn_d        = dn_q;
    done_d      = frame_done_c;
    head_flag_d = done_q;
    if (frame_done_c) begin
      for (int c = 0; c < NUM_CH; c++) begin
        dl_d[c][0] = cur[c];
        for (int k = 1; k < MAX_DELAY; k++) dl_d[c][k] = dl_q[c][k-1];
      end
      dn_d = WORD_W'(sum_c >>> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NUM_CH - 1; i++) samp_q[i] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < MAX_DELAY; k++) dl_q[c][k] <= '0;
      dn_q        <= '0;
      done_q      <= 1'b0;
      head_flag_q <= 1'b0;
    end else begin
      samp_q      <= samp_d;
      dl_q        <= dl_d;
      dn_q        <= dn_d;
      done_q      <= done_d;
      head_flag_q <= head_flag_d;
    end
  end

  assign dn        = dn_q;
  assign head_flag = head_flag_q;

endmodule

// File: tb/tb_four_ch_delay_top.sv
// Directed bench for four_ch_delay_top: frame table plus hand sequences for
// miso readback, discarded words and reset mid-frame.
module tb_four_ch_delay_top;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs = 1'b1;
  logic miso;
  logic signed [13:0] dn;
  logic head_flag;

  int errors = 0;
  int checks = 0;
  int hf_cnt = 0;
  int hf_wide = 0;
  logic hf_last = 1'b0;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int s3;
    int exp_dn;
  } vec_t;

  vec_t vecs [17];

  four_ch_delay_top dut (
    .clk       (clk),
    .rstn      (rstn),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .miso      (miso),
    .dn        (dn),
    .head_flag (head_flag)
  );

  always #5 clk = ~clk;

  // Count head_flag pulses and flag any pulse wider than one clk
  always @(negedge clk) begin
    if (head_flag) hf_cnt++;
    if (head_flag && hf_last) hf_wide++;
    hf_last = head_flag;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    wait_clk(4);
    rstn = 1'b0;
    wait_clk(2);
  endtask

  // One cs-low window carrying the low nbits of w, MSB first
  task automatic spi_word(input logic [13:0] w, input int nbits);
    cs = 1'b0;
    wait_clk(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = w[i];
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(4);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(6);
  endtask

  task automatic send_frame(input int s0, input int s1, input int s2, input int s3);
    spi_word(14'h0FFF, 14);
    spi_word(14'(s0), 14);
    spi_word(14'(s1), 14);
    spi_word(14'(s2), 14);
    spi_word(14'(s3), 14);
    wait_clk(4);
  endtask

  task automatic frame_check(input string name, input int s0, input int s1,
                             input int s2, input int s3, input int exp_dn);
    int hf0;
    hf0 = hf_cnt;
    send_frame(s0, s1, s2, s3);
    check({name, " dn"}, int'(dn), exp_dn);
    check({name, " head_flag"}, hf_cnt - hf0, 1);
  endtask

  task automatic run_vec(input int i);
    frame_check($sformatf("frame%0d", i), vecs[i].s0, vecs[i].s1,
                vecs[i].s2, vecs[i].s3, vecs[i].exp_dn);
  endtask

  initial begin
    logic [13:0] rd;
    int hf0;

    vecs[0]  = '{100, 200, 300, 400, 25};
    vecs[1]  = '{100, 200, 300, 400, 75};
    vecs[2]  = '{100, 200, 300, 400, 150};
    vecs[3]  = '{100, 200, 300, 400, 250};
    vecs[4]  = '{-8000, -8000, -8000, -8000, -1775};
    vecs[5]  = '{-8000, -8000, -8000, -8000, -3825};
    vecs[6]  = '{-8000, -8000, -8000, -8000, -5900};
    vecs[7]  = '{-8000, -8000, -8000, -8000, -8000};
    vecs[8]  = '{-8192, -8192, -8192, -8192, -8048};
    vecs[9]  = '{-8192, -8192, -8192, -8192, -8096};
    vecs[10] = '{-8192, -8192, -8192, -8192, -8144};
    vecs[11] = '{-8192, -8192, -8192, -8192, -8192};
    vecs[12] = '{-1, 0, 0, 0, -6145};
    vecs[13] = '{-1, 0, 0, 0, -4097};
    vecs[14] = '{-1, 0, 0, 0, -2049};
    vecs[15] = '{-1, 0, 0, 0, -1};
    vecs[16] = '{1, 0, 0, 0, 0};

    // Reset state with no SPI traffic
    do_reset();
    wait_clk(10);
    check("reset dn", int'(dn), 0);
    check("reset head_flag", int'(head_flag), 0);
    check("reset miso", int'(miso), 0);
    check("reset hf pulses", hf_cnt, 0);

    for (int i = 0; i < 4; i++) run_vec(i);

    // miso readback of dn=250 during a cs-low window
    cs = 1'b0;
    wait_clk(8);
    for (int i = 13; i >= 0; i--) begin
      rd[i] = miso;
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
      wait_clk(8);
    end
    cs = 1'b1;
    wait_clk(8);
    check("miso readback", int'(rd), 14'b00000011111010);
    check("miso idle", int'(miso), 0);
    check("dn after readback", int'(dn), 250);

    for (int i = 4; i < 17; i++) run_vec(i);

    // Stray word before header, 13-bit window mid-frame, 0x0FFF as CH2 data
    do_reset();
    check("reset2 dn", int'(dn), 0);
    hf0 = hf_cnt;
    spi_word(14'h1234, 14);
    wait_clk(4);
    check("stray word no flag", hf_cnt - hf0, 0);
    spi_word(14'h0FFF, 14);
    spi_word(14'd12, 14);
    spi_word(14'h1555, 13);
    spi_word(14'd20, 14);
    spi_word(14'h0FFF, 14);
    spi_word(14'd40, 14);
    wait_clk(4);
    check("frameX dn", int'(dn), 3);
    check("frameX head_flag", hf_cnt - hf0, 1);
    frame_check("frameY", 0, 0, 0, 0, 5);
    frame_check("frameZ", 0, 0, 0, 0, 1023);
    frame_check("frameW", 0, 0, 0, 0, 10);

    // Reset mid-frame aborts it; following frame is accepted
    hf0 = hf_cnt;
    spi_word(14'h0FFF, 14);
    spi_word(14'd7, 14);
    spi_word(14'd8, 14);
    do_reset();
    spi_word(14'd9, 14);
    spi_word(14'd10, 14);
    wait_clk(4);
    check("abort no flag", hf_cnt - hf0, 0);
    check("abort dn", int'(dn), 0);
    frame_check("after abort", 50, 0, 0, 0, 12);

    check("head_flag width", hf_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
